// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, controller state encoding, PC-select codes
// and the opcode-class bundle used by the controller and the instruction register.
package cpu_pkg;

    localparam logic [5:0] OPC_NOP   = 6'd0;
    localparam logic [5:0] OPC_ADD   = 6'd1;
    localparam logic [5:0] OPC_SUB   = 6'd2;
    localparam logic [5:0] OPC_STORE = 6'd3;
    localparam logic [5:0] OPC_LOAD  = 6'd4;
    localparam logic [5:0] OPC_AND   = 6'd5;
    localparam logic [5:0] OPC_OR    = 6'd6;
    localparam logic [5:0] OPC_XOR   = 6'd7;
    localparam logic [5:0] OPC_NOT   = 6'd8;
    localparam logic [5:0] OPC_SL    = 6'd9;
    localparam logic [5:0] OPC_SR    = 6'd10;
    localparam logic [5:0] OPC_SLI   = 6'd11;
    localparam logic [5:0] OPC_SRI   = 6'd12;
    localparam logic [5:0] OPC_ADDI  = 6'd13;
    localparam logic [5:0] OPC_SUBI  = 6'd14;
    localparam logic [5:0] OPC_MOV   = 6'd15;
    localparam logic [5:0] OPC_MOVEI = 6'd16;
    localparam logic [5:0] OPC_CMP   = 6'd17;
    localparam logic [5:0] OPC_INC   = 6'd18;
    localparam logic [5:0] OPC_DEC   = 6'd19;
    localparam logic [5:0] OPC_MUL   = 6'd20;
    localparam logic [5:0] OPC_JUMP  = 6'd21;
    localparam logic [5:0] OPC_BRA   = 6'd22;
    localparam logic [5:0] OPC_LAST  = OPC_BRA;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [1:0] PC_SEL_INC  = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP = 2'b01;
    localparam logic [1:0] PC_SEL_BRA  = 2'b10;

    typedef struct packed {
        logic is_alu;
        logic is_imm;
        logic is_mem;
        logic is_wb;
        logic is_ctl;
        logic is_illegal;
    } opc_class_t;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Controller <-> datapath bundle: sequencing inputs and the control strobes.
// The controller uses the master view; the datapath (or a bench) uses slave.
interface cpu_ctrl_fsm_if;

    logic        run;
    logic [5:0]  opc;
    logic        br_cond;
    logic        mem_ready;

    logic        ir_load;
    logic        pc_en;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        alu_src_imm;
    logic        busy;
    logic        halted;
    logic [1:0]  pc_sel;
    logic [5:0]  alu_op;
    logic [15:0] retired;

    modport master (
        input  run, opc, br_cond, mem_ready,
        output ir_load, pc_en, reg_we, mem_rd, mem_wr, alu_src_imm,
               busy, halted, pc_sel, alu_op, retired
    );

    modport slave (
        output run, opc, br_cond, mem_ready,
        input  ir_load, pc_en, reg_we, mem_rd, mem_wr, alu_src_imm,
               busy, halted, pc_sel, alu_op, retired
    );

endinterface

// File: rtl/cpu_opc_class.sv
// Combinational opcode classifier: sorts an opcode into the instruction
// families that steer the controller's path through EXEC/MEM/WB.
module cpu_opc_class
    import cpu_pkg::*;
(
    input  logic [5:0]  opc,
    output opc_class_t  cls
);

    always_comb begin
        cls            = '0;
        cls.is_illegal = (opc > OPC_LAST);
        cls.is_mem     = (opc == OPC_LOAD) || (opc == OPC_STORE);
        cls.is_ctl     = (opc == OPC_NOP) || (opc == OPC_JUMP) || (opc == OPC_BRA);
        cls.is_alu     = opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
                                     OPC_NOT, OPC_SL, OPC_SR, OPC_SLI, OPC_SRI,
                                     OPC_ADDI, OPC_SUBI, OPC_MOV, OPC_MOVEI,
                                     OPC_CMP, OPC_INC, OPC_DEC, OPC_MUL};
        cls.is_wb      = cls.is_alu || (opc == OPC_LOAD);
        cls.is_imm     = opc inside {OPC_MOVEI, OPC_SLI, OPC_SRI, OPC_ADDI,
                                     OPC_SUBI, OPC_LOAD, OPC_STORE};
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC with optional MEM and WB
// steps, a retired-instruction counter and a sticky HALT on illegal opcodes.
module cpu_ctrl_fsm
    import cpu_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    cpu_ctrl_fsm_if.master bus
);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] retired_q;
    logic        end_instr;
    logic        in_op;
    opc_class_t  cls;

    cpu_opc_class u_opc_class (
        .opc (bus.opc),
        .cls (cls)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_nxt = state;
        end_instr = 1'b0;
        case (state)
            ST_IDLE:   if (bus.run) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = cls.is_illegal ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (cls.is_mem)      state_nxt = ST_MEM;
                else if (cls.is_alu) state_nxt = ST_WB;
                else                 end_instr = 1'b1;
            end
            ST_MEM: begin
                // mem_ready only matters here; LOAD still owes a write-back.
                if (bus.mem_ready) begin
                    if (cls.is_wb) state_nxt = ST_WB;
                    else           end_instr = 1'b1;
                end
            end
            ST_WB:     end_instr = 1'b1;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
        // run is only consulted at instruction boundaries, so dropping it never aborts.
        if (end_instr) state_nxt = bus.run ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments and an async clear.
        if (!reset_n) begin
            state     <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            if (end_instr) retired_q <= retired_q + 16'd1;
        end
    end

    assign in_op = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);

    assign bus.ir_load     = (state == ST_FETCH);
    assign bus.pc_en       = end_instr;
    assign bus.reg_we      = (state == ST_WB) && cls.is_wb;
    assign bus.mem_rd      = (state == ST_MEM) && cls.is_mem && cls.is_wb;
    assign bus.mem_wr      = (state == ST_MEM) && cls.is_mem && !cls.is_wb;
    assign bus.alu_src_imm = in_op && cls.is_imm;
    assign bus.alu_op      = !in_op ? 6'd0 : (cls.is_mem ? OPC_ADD : bus.opc);
    assign bus.busy        = (state != ST_IDLE) && (state != ST_HALT);
    assign bus.halted      = (state == ST_HALT);
    assign bus.retired     = retired_q;

    always_comb begin
        bus.pc_sel = PC_SEL_INC;
        if ((state == ST_EXEC) && cls.is_ctl) begin
            if (bus.opc == OPC_JUMP)                   bus.pc_sel = PC_SEL_JUMP;
            else if ((bus.opc == OPC_BRA) && bus.br_cond) bus.pc_sel = PC_SEL_BRA;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed and randomized instruction
// streams compared cycle by cycle against a latency-table reference model.
module tb_cpu_ctrl_fsm;

    typedef struct packed {
        logic        ir_load;
        logic        pc_en;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        imm;
        logic        busy;
        logic        halted;
        logic [1:0]  pc_sel;
        logic [5:0]  alu_op;
        logic [15:0] retired;
    } obs_t;

    logic clock;
    logic reset_n;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_retired;
    bit          gi;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // pc_sel carries meaning only alongside pc_en, so it is masked otherwise.
    function automatic obs_t observe();
        obs_t o;
        o.ir_load = bus.ir_load;
        o.pc_en   = bus.pc_en;
        o.reg_we  = bus.reg_we;
        o.mem_rd  = bus.mem_rd;
        o.mem_wr  = bus.mem_wr;
        o.imm     = bus.alu_src_imm;
        o.busy    = bus.busy;
        o.halted  = bus.halted;
        o.pc_sel  = bus.pc_en ? bus.pc_sel : 2'b00;
        o.alu_op  = bus.alu_op;
        o.retired = bus.retired;
        return o;
    endfunction

    function automatic int instr_len(input logic [5:0] op, input int w);
        if (op == 6'd0 || op == 6'd21 || op == 6'd22) return 3;
        if (op == 6'd3) return 4 + w;
        if (op == 6'd4) return 5 + w;
        return 4;
    endfunction

    task automatic step(input string tag, input obs_t e);
        @(negedge clock);
        check(tag, observe(), e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_then_start(input int n);
        obs_t e;
        e = '0;
        e.retired = exp_retired;
        for (int i = 0; i < n; i++) begin
            bus.run       = 1'b0;
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.br_cond   = 1'($urandom_range(0, 1));
            step("idle", e);
        end
        bus.run = 1'b1;
        step("idle_go", e);
    endtask

    // Entered one cycle into FETCH; leaves just after the final edge of the instruction.
    task automatic exec_instr(input logic [5:0] op, input int w, input int brc,
                              input int drop_at, input int abort_at, output bit went_idle);
        bit   ld, st, ctl, alu, imm, last, in_mem;
        int   len;
        obs_t e;
        ld  = (op == 6'd4);
        st  = (op == 6'd3);
        ctl = (op == 6'd0 || op == 6'd21 || op == 6'd22);
        alu = !ld && !st && !ctl;
        imm = (op == 6'd3 || op == 6'd4 || op == 6'd11 || op == 6'd12 ||
               op == 6'd13 || op == 6'd14 || op == 6'd16);
        len = instr_len(op, w);
        went_idle = (drop_at >= 0);
        bus.opc = op;
        for (int k = 0; k < len; k++) begin
            last   = (k == len - 1);
            in_mem = (ld || st) && k >= 3 && k <= 3 + w;
            bus.run       = (drop_at >= 0 && k >= drop_at) ? 1'b0 : 1'b1;
            bus.mem_ready = in_mem ? (k == 3 + w) : 1'($urandom_range(0, 1));
            bus.br_cond   = (brc >= 0) ? 1'(brc) : 1'($urandom_range(0, 1));
            e = '0;
            e.busy    = 1'b1;
            e.retired = exp_retired;
            e.ir_load = (k == 0);
            if (k >= 2) begin
                e.alu_op = (ld || st) ? 6'd1 : op;
                e.imm    = imm;
            end
            e.mem_rd = in_mem && ld;
            e.mem_wr = in_mem && st;
            if (last) begin
                e.pc_en  = 1'b1;
                e.reg_we = alu || ld;
                if (op == 6'd21)                     e.pc_sel = 2'b01;
                else if (op == 6'd22 && bus.br_cond) e.pc_sel = 2'b10;
            end
            if (k == abort_at) begin
                @(negedge clock);
                check($sformatf("op%0d_k%0d_pre_abort", op, k), observe(), e);
                #2 reset_n = 1'b0;
                #1 check("async_reset", observe(), 32'd0);
                exp_retired = '0;
                @(posedge clock);
                #1;
                reset_n   = 1'b1;
                bus.run   = 1'b0;
                went_idle = 1'b1;
                return;
            end
            step($sformatf("op%0d_w%0d_k%0d", op, w, k), e);
            if (last) exp_retired = exp_retired + 16'd1;
        end
    endtask

    initial begin
        obs_t e;
        reset_n       = 1'b1;
        bus.run       = 1'b0;
        bus.opc       = 6'd0;
        bus.br_cond   = 1'b0;
        bus.mem_ready = 1'b0;
        exp_retired   = '0;
        #1 reset_n = 1'b0;
        #1 check("reset_outputs", observe(), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        idle_then_start(2);

        // ADD back to back, then LOAD with three wait cycles.
        exec_instr(6'd1, 0, -1, -1, -1, gi);
        check("add_retired", 32'(bus.retired), 32'd1);
        exec_instr(6'd4, 3, -1, -1, -1, gi);
        exec_instr(6'd22, 0, 1, -1, -1, gi);
        exec_instr(6'd22, 0, 0, -1, -1, gi);
        exec_instr(6'd21, 0, -1, -1, -1, gi);
        exec_instr(6'd3, 0, -1, -1, -1, gi);
        exec_instr(6'd3, 2, -1, -1, -1, gi);
        exec_instr(6'd13, 0, -1, 1, -1, gi);
        idle_then_start(1);

        for (int i = 0; i < 250; i++) begin
            logic [5:0] op;
            int         w, len, drop;
            op   = 6'($urandom_range(0, 22));
            w    = $urandom_range(0, 4);
            len  = instr_len(op, w);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            exec_instr(op, w, -1, drop, -1, gi);
            if (gi) idle_then_start($urandom_range(0, 2));
        end

        // Counter wrap: park in IDLE, preload the count just below wrap, retire one NOP.
        exec_instr(6'd0, 0, -1, 0, -1, gi);
        force dut.retired_q = 16'hFFFF;
        #1 release dut.retired_q;
        exp_retired = 16'hFFFF;
        idle_then_start(1);
        exec_instr(6'd0, 0, -1, 0, -1, gi);
        check("retired_wrap", 32'(bus.retired), 32'd0);
        idle_then_start(1);

        // Reset lands in the middle of a STORE's memory wait.
        exec_instr(6'd5, 0, -1, -1, -1, gi);
        exec_instr(6'd3, 6, -1, -1, 5, gi);
        idle_then_start(2);

        // Illegal opcode: sticky HALT with run held high.
        bus.opc = 6'h3F;
        bus.run = 1'b1;
        e = '0; e.retired = exp_retired; e.busy = 1'b1; e.ir_load = 1'b1;
        step("illegal_fetch", e);
        e.ir_load = 1'b0;
        step("illegal_decode", e);
        e.busy = 1'b0; e.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.br_cond   = 1'($urandom_range(0, 1));
            step($sformatf("halt_c%0d", i), e);
        end
        reset_n = 1'b0;
        #1 check("halt_reset", observe(), 32'd0);
        exp_retired = '0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        bus.opc = 6'd1;
        idle_then_start(1);
        exec_instr(6'd1, 0, -1, 0, -1, gi);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port run, input, 1, level enable: while high, instructions are sequenced back to back.
REQ-004 SHALL have port opc, input, 6, opcode from the instruction register, valid from DECODE onward.
REQ-005 SHALL have port br_cond, input, 1, datapath branch-compare result, sampled in EXEC.
REQ-006 SHALL have port mem_ready, input, 1, data-memory completion handshake.
REQ-007 SHALL have outputs ir_load, pc_en, reg_we, mem_rd, mem_wr, alu_src_imm, busy, halted (each 1 bit), plus pc_sel (2), alu_op (6) and retired (16).

Function
REQ-008 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-009 IDLE -> FETCH SHALL occur when run=1; otherwise the FSM stays in IDLE.
REQ-010 FETCH SHALL assert ir_load for exactly one cycle, then go to DECODE.
REQ-011 DECODE SHALL go to HALT if opc>22 (illegal); otherwise it SHALL go to EXEC.
REQ-012 EXEC SHALL drive alu_op=opc, except LOAD(4)/STORE(3), which SHALL drive 000001 (ADD).
REQ-013 alu_src_imm SHALL be 1 in EXEC/MEM/WB for MOVEI, SLI, SRI, ADDI, SUBI, LOAD, STORE; alu_op and alu_src_imm SHALL be 0 in all other states.
REQ-014 From EXEC, the FSM SHALL go to MEM for LOAD/STORE, WB for opcodes 1,2,5-20, and the end-of-instruction step for NOP, JUMP, BRA.
REQ-015 MEM SHALL hold mem_rd (LOAD) or mem_wr (STORE) high until mem_ready=1 with no timeout; on ready, LOAD SHALL go to WB and STORE to end-of-instruction.
REQ-016 WB SHALL assert reg_we for exactly one cycle.
REQ-017 End-of-instruction (last cycle of EXEC, MEM or WB) SHALL pulse pc_en once and increment retired, which wraps FFFF->0000.
REQ-018 pc_sel SHALL be 00 (PC+1) by default, 01 for JUMP, 10 for BRA with br_cond=1, and 00 for BRA with br_cond=0; it is valid only while pc_en=1.
REQ-019 After end-of-instruction, the FSM SHALL go to FETCH if run=1, else IDLE.
REQ-020 Deasserting run mid-instruction SHALL NOT abort the instruction; it completes, then the FSM goes to IDLE.
REQ-021 Latencies SHALL be: NOP/JUMP/BRA 3 cycles; ALU ops 4; STORE 4+w; LOAD 5+w (w = mem_ready wait cycles).
REQ-022 busy SHALL be 1 in every state except IDLE and HALT.
REQ-023 HALT SHALL be sticky: halted=1, no pc_en/reg_we/mem strobes, and exit only by reset.
REQ-024 mem_ready while not in MEM SHALL be ignored.
REQ-025 mem_rd and mem_wr SHALL never be high in the same cycle.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE and drive all outputs to 0, including retired=0000.
REQ-027 Reset mid-MEM SHALL drop mem_rd/mem_wr asynchronously, with no completion pulse.
REQ-028 On reset release, the first FETCH SHALL occur on the first rising edge with run=1.

Structure
REQ-029 Opcode constants (NOP=0 ... BRA=22), the state encoding, and the pc_sel encodings SHALL reside in shared package cpu_pkg, also used by the instruction register.
REQ-030 One sub-module, cpu_opc_class, SHALL be used: a combinational opcode classifier (is_alu, is_imm, is_mem, is_wb, is_ctl, is_illegal).
REQ-031 State, retired and all registered outputs SHALL be flops on clock with async clear from reset_n.

Verification
REQ-032 ADD (opc=1), run=1 -> ir_load@c0, reg_we@c3, pc_en@c3 with pc_sel=00, retired=1.
REQ-033 LOAD (opc=4) with mem_ready delayed 3 cycles -> mem_rd held for 4 cycles, reg_we 1 cycle after mem_ready, total 8 cycles.
REQ-034 BRA (opc=22), br_cond=1 -> pc_sel=10; br_cond=0 -> pc_sel=00; both at c2, with no reg_we.
REQ-035 opc=6'h3F -> HALT at the cycle after DECODE, halted=1, and no strobes for 20 cycles while run=1.
REQ-036 Preload retired=FFFF via a 65535-NOP run, then one more NOP -> retired=0000.
REQ-037 reset_n low mid-MEM of a STORE -> mem_wr=0 immediately, state IDLE, retired=0.
